// File: rtl/ecc32_encoder.sv
// Two-stage streaming SEC check-bit encoder with optional single-bit fault injection.
// S1 captures the word and its nibble parities; S2 forms c0..c7, applies injection, drives the outputs.
module ecc32_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             inj_en,
  input  logic [5:0]       inj_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [7:0]       out_check,
  output logic [CNT_W-1:0] word_cnt
);

  logic        s1_valid;
  logic [31:0] s1_data;
  logic        s1_inj_en;
  logic [5:0]  s1_inj_idx;
  logic [7:0]  s1_nib;

  logic        s2_load;
  logic        s1_adv;
  logic        in_fire;
  logic        out_fire;

  logic [7:0]  nib_par;
  logic [3:0]  lo_col;
  logic [3:0]  hi_col;
  logic [7:0]  chk;
  logic [39:0] flip;
  logic [39:0] cw;

  // S2 frees up whenever it is empty or its word leaves; in_ready never looks at in_valid.
  assign out_fire = out_valid && out_ready;
  assign s2_load  = !out_valid || out_ready;
  assign s1_adv   = s1_valid && s2_load;
  assign in_ready = !s1_valid || s2_load;
  assign in_fire  = in_valid && in_ready;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    nib_par = '0;
    for (int n = 0; n < 8; n++) nib_par[n] = ^in_data[4*n +: 4];
  end

  // Column parities: bit j of every nibble in the low and high halves.
  always_comb begin
    lo_col = '0;
    hi_col = '0;
    for (int j = 0; j < 4; j++) begin
      lo_col[j] = s1_data[j] ^ s1_data[4+j] ^ s1_data[8+j] ^ s1_data[12+j];
      hi_col[j] = s1_data[16+j] ^ s1_data[20+j] ^ s1_data[24+j] ^ s1_data[28+j];
    end
  end

  always_comb begin
    chk[0] = lo_col[0] ^ s1_nib[4] ^ s1_nib[5];
    chk[1] = lo_col[1] ^ s1_nib[6] ^ s1_nib[7];
    chk[2] = lo_col[2] ^ s1_nib[4] ^ s1_nib[6];
    chk[3] = lo_col[3] ^ s1_nib[5] ^ s1_nib[7];
    chk[4] = s1_nib[0] ^ s1_nib[1] ^ hi_col[0];
    chk[5] = s1_nib[2] ^ s1_nib[3] ^ hi_col[1];
    chk[6] = s1_nib[0] ^ s1_nib[2] ^ hi_col[2];
    chk[7] = s1_nib[1] ^ s1_nib[3] ^ hi_col[3];
    flip   = (s1_inj_en && (s1_inj_idx < 6'd40)) ? (40'd1 << s1_inj_idx) : '0;
    cw     = {chk, s1_data} ^ flip;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_data    <= '0;
      s1_inj_en  <= 1'b0;
      s1_inj_idx <= '0;
      s1_nib     <= '0;
    end else if (in_fire) begin
      s1_valid   <= 1'b1;
      s1_data    <= in_data;
      s1_inj_en  <= inj_en;
      s1_inj_idx <= inj_idx;
      s1_nib     <= nib_par;
    end else if (s1_adv) begin
      s1_valid   <= 1'b0;
    end
  end

  // Output payload only changes on a load with a word behind it, so it holds under back-pressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_check <= '0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data  <= cw[31:0];
        out_check <= cw[39:32];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        word_cnt <= '0;
    else if (out_fire) word_cnt <= word_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_ecc32_encoder.sv
// Scoreboard bench for ecc32_encoder: reference parity masks, a SEC corrector model, handshake scenarios.
module tb_ecc32_encoder;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             inj_en;
  logic [5:0]       inj_idx;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [7:0]       out_check;
  logic [CNT_W-1:0] word_cnt;

  int errors = 0;
  int checks = 0;
  logic [39:0] exp_q[$];
  logic [31:0] orig_q[$];
  logic [CNT_W-1:0] exp_cnt;

  ecc32_encoder #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .inj_en(inj_en), .inj_idx(inj_idx),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_check(out_check), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1);
  end

  // Group membership masks written straight from the check-bit equations.
  function automatic logic [7:0] ref_check(input logic [31:0] d);
    logic [31:0] m [8];
    m[0] = 32'h00FF1111; m[1] = 32'hFF002222; m[2] = 32'h0F0F4444; m[3] = 32'hF0F08888;
    m[4] = 32'h111100FF; m[5] = 32'h2222FF00; m[6] = 32'h44440F0F; m[7] = 32'h8888F0F0;
    for (int i = 0; i < 8; i++) ref_check[i] = ^(d & m[i]);
  endfunction

  function automatic logic [39:0] ref_cw(input logic [31:0] d, input logic en, input logic [5:0] idx);
    ref_cw = {ref_check(d), d};
    if (en && idx < 6'd40) ref_cw[idx] = ~ref_cw[idx];
  endfunction

  // SEC corrector model: the syndrome matches the column of the flipped data bit.
  function automatic logic [31:0] correct(input logic [31:0] d, input logic [7:0] c);
    logic [7:0] syn;
    syn = ref_check(d) ^ c;
    correct = d;
    for (int k = 0; k < 32; k++)
      if (syn != 8'h00 && syn == ref_check(32'd1 << k)) correct[k] = ~d[k];
  endfunction

  // One clock: called at a negedge with inputs already driven; samples handshake before the edge.
  task automatic tick(output bit acc, output bit del, output logic [39:0] cw);
    #1;
    acc = in_valid && in_ready;
    del = out_valid && out_ready;
    cw  = {out_check, out_data};
    @(posedge clk);
    @(negedge clk);
    if (del) exp_cnt++;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_data = '0; inj_en = 1'b0; inj_idx = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    out_ready = 1'b1;
    rst_n = 1'b0;
    exp_cnt = '0;
    #13;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (word_cnt !== '0) begin errors++; $display("FAIL reset_word_cnt: got %0d want 0", word_cnt); end
    checks++; if ({out_check, out_data} !== 40'h0) begin errors++; $display("FAIL reset_payload: got %h want 0", {out_check, out_data}); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  // Single words through an empty pipe; also pins the two-edge latency.
  task automatic send_one(input string name, input logic [31:0] d, input logic en, input logic [5:0] idx,
                          input logic [31:0] want_d, input logic [7:0] want_c);
    bit acc, del;
    logic [39:0] cw;
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = d; inj_en = en; inj_idx = idx;
    tick(acc, del, cw);
    idle_inputs();
    checks++; if (acc !== 1'b1) begin errors++; $display("FAIL %s_accept: got %b want 1", name, acc); end
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_early: out_valid %b want 0 after one edge", name, out_valid); end
    tick(acc, del, cw);
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL %s_latency: out_valid %b want 1", name, out_valid); end
    checks++; if (out_data !== want_d || out_check !== want_c) begin
      errors++; $display("FAIL %s_codeword: got %h/%h want %h/%h", name, out_data, out_check, want_d, want_c);
    end
    tick(acc, del, cw);
  endtask

  task automatic test_basic();
    send_one("enc_zero", 32'h00000000, 1'b0, 6'd0, 32'h00000000, 8'h00);
    send_one("enc_d0",   32'h00000001, 1'b0, 6'd0, 32'h00000001, 8'h51);
    send_one("enc_d31",  32'h80000000, 1'b0, 6'd0, 32'h80000000, 8'h8A);
    send_one("enc_ones", 32'hFFFFFFFF, 1'b0, 6'd0, 32'hFFFFFFFF, 8'h00);
  endtask

  task automatic test_inject();
    send_one("inj_d0",   32'h00000001, 1'b1, 6'd0,  32'h00000000, 8'h51);
    send_one("inj_c4",   32'h00000001, 1'b1, 6'd36, 32'h00000001, 8'h41);
    send_one("inj_none", 32'h00000001, 1'b1, 6'd45, 32'h00000001, 8'h51);
  endtask

  task automatic test_backpressure();
    bit acc, del;
    logic [39:0] cw, hold;
    logic [31:0] w [4];
    int idx = 0;
    int delivered = 0;
    for (int i = 0; i < 4; i++) w[i] = $urandom();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = w[idx];
      tick(acc, del, cw);
      if (acc) begin exp_q.push_back(ref_cw(w[idx], 1'b0, 6'd0)); idx++; end
    end
    checks++; if (idx != 2) begin errors++; $display("FAIL bp_accepts: got %0d want 2", idx); end
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
    hold = {out_check, out_data};
    for (int i = 0; i < 3; i++) begin
      in_data = w[idx];
      tick(acc, del, cw);
      checks++; if (out_valid !== 1'b1 || {out_check, out_data} !== hold) begin
        errors++; $display("FAIL bp_stable: got %b/%h want 1/%h", out_valid, {out_check, out_data}, hold);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_recovery: in_ready %b want 1", in_ready); end
    for (int c = 0; c < 20 && delivered < 4; c++) begin
      in_valid = (idx < 4);
      in_data  = (idx < 4) ? w[idx] : '0;
      tick(acc, del, cw);
      if (del) begin
        delivered++;
        checks++; if (exp_q.size() == 0 || cw !== exp_q[0]) begin
          errors++; $display("FAIL bp_order: got %h want %h", cw, exp_q.size() ? exp_q[0] : 40'hx);
        end
        if (exp_q.size()) void'(exp_q.pop_front());
      end
      if (acc) begin exp_q.push_back(ref_cw(w[idx], 1'b0, 6'd0)); idx++; end
    end
    idle_inputs();
    checks++; if (delivered != 4 || exp_q.size() != 0) begin
      errors++; $display("FAIL bp_drain: got %0d delivered %0d left want 4 0", delivered, exp_q.size());
    end
  endtask

  // Streams n words; inj selects random injection. Checks codeword, corrector result, and rate.
  task automatic run_stream(input string name, input int n, input bit inj);
    bit acc, del;
    logic [39:0] cw;
    logic [31:0] d;
    logic [5:0] ix;
    int sent = 0, got = 0, stalls = 0, gaps = 0;
    out_ready = 1'b1;
    for (int c = 0; c < n + 50 && got < n; c++) begin
      if (sent < n) begin
        d = $urandom(); ix = 6'($urandom_range(39, 0));
        in_valid = 1'b1; in_data = d; inj_en = inj; inj_idx = ix;
      end else idle_inputs();
      tick(acc, del, cw);
      if (sent < n && !acc) stalls++;
      if (got > 0 && got < n && !del) gaps++;
      if (del) begin
        got++;
        checks++; if (exp_q.size() == 0 || cw !== exp_q[0] || correct(cw[31:0], cw[39:32]) !== orig_q[0]) begin
          errors++; $display("FAIL %s_word%0d: got %h corr %h want %h orig %h", name, got, cw,
                             correct(cw[31:0], cw[39:32]), exp_q.size() ? exp_q[0] : 40'hx, orig_q.size() ? orig_q[0] : 32'hx);
        end
        if (exp_q.size()) begin void'(exp_q.pop_front()); void'(orig_q.pop_front()); end
      end
      if (acc) begin exp_q.push_back(ref_cw(d, inj, ix)); orig_q.push_back(d); sent++; end
    end
    idle_inputs();
    checks++; if (got != n || stalls != 0 || gaps != 0) begin
      errors++; $display("FAIL %s_rate: got %0d words %0d stalls %0d gaps want %0d 0 0", name, got, stalls, gaps, n);
    end
  endtask

  task automatic test_stream();
    run_stream("stream", 1000, 1'b0);
  endtask

  task automatic test_single_error();
    run_stream("seu", 200, 1'b1);
    checks++; if (word_cnt !== exp_cnt) begin errors++; $display("FAIL cnt_track: got %0d want %0d", word_cnt, exp_cnt); end
  endtask

  task automatic test_counter();
    rst_n = 1'b0; #3; rst_n = 1'b1;
    exp_cnt = '0;
    @(negedge clk);
    run_stream("cnt", 17, 1'b0);
    checks++; if (word_cnt !== 4'd1) begin errors++; $display("FAIL cnt_wrap: got %0d want 1", word_cnt); end
  endtask

  task automatic test_reset_midstream();
    bit acc, del;
    logic [39:0] cw;
    int stale = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = $urandom();
      tick(acc, del, cw);
    end
    idle_inputs();
    #1;
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL rst_full: in_ready %b out_valid %b want 0 1", in_ready, out_valid);
    end
    #2; rst_n = 1'b0; #1;
    checks++; if (out_valid !== 1'b0 || word_cnt !== '0) begin
      errors++; $display("FAIL rst_async: out_valid %b word_cnt %0d want 0 0", out_valid, word_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(acc, del, cw);
      if (del) stale++;
    end
    checks++; if (stale != 0) begin errors++; $display("FAIL rst_stale: got %0d words want 0", stale); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_inject();
    test_backpressure();
    test_stream();
    test_single_error();
    test_counter();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
